ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage directly downstream of the load/operand pipeline register; consumes its two 6-bit operands, ALU opcode, mul/add select, destination address, store flag and halt flag.
- Performs single-cycle ALU ops and a multi-cycle shift-add multiply.
- Drives `freeze` back to upstream stages while a multiply is in progress.
- Registers results for writeback.

Parameters:
- DATA_W, 6, operand/result width; multiply takes DATA_W iterations.
- ADR_W, 6, destination register address width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream holds a real instruction (0 = bubble)
- halted_in  input  1  upstream halt flag
- write_adr_in  input  ADR_W  destination register address
- alu_inst_in  input  2  00 add, 01 sub, 10 and, 11 xor
- op_a  input  DATA_W  operand 1
- op_b  input  DATA_W  operand 2
- data_mem_write_in  input  1  instruction is a store
- mul_or_add_in  input  1  1 = multiply (alu_inst ignored), 0 = ALU op
- freeze  output  1  stall request to upstream stages (combinational)
- result_out  output  DATA_W  registered result (low DATA_W bits)
- write_adr_out  output  ADR_W  registered destination
- wb_en_out  output  1  registered register-file write enable
- data_mem_write_out  output  1  registered store flag
- mem_wdata_out  output  DATA_W  registered store data (op_b)
- halted_out  output  1  sticky halt indication
- ovf_out  output  1  overflow flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, iteration counter=0, multiplier accumulator=0.
  - All registered outputs = 0; freeze=0 immediately.
- Accept condition: state==IDLE && in_valid && !halted_out.
- States IDLE, MUL, DONE.
- IDLE, accepted, mul_or_add_in=0:
  - At the edge, result_out = op per alu_inst_in, mod 2^DATA_W (sub wraps two's complement).
  - write_adr_out, data_mem_write_out, mem_wdata_out=op_b loaded.
  - wb_en_out = !data_mem_write_in && !halted_in.
  - Latency 1 cycle; freeze=0.
- IDLE, accepted, mul_or_add_in=1:
  - freeze=1 combinationally this cycle.
  - At the edge: latch op_a/op_b/write_adr; state→MUL; cnt=0; wb_en_out→0.
- MUL:
  - freeze=1; one multiplier bit per cycle (if b[cnt], acc += a<<cnt; acc is 2*DATA_W wide).
  - cnt==DATA_W-1 at the edge → DONE.
- DONE:
  - freeze=0; inputs ignored (upstream still shows the same mul and advances at this edge).
  - At the edge: result_out=acc[DATA_W-1:0], wb_en_out=1, data_mem_write_out=0, state→IDLE.
- Multiply timing: freeze high exactly DATA_W+1 cycles; result visible DATA_W+2 edges after the first accept cycle.
- Not accepted in IDLE (bubble or halted_out): wb_en_out→0 and data_mem_write_out→0 at the edge; other outputs hold.
- Halt:
  - An accepted instruction with halted_in=1 sets halted_out=1 at that edge; it stays 1 until reset.
  - wb_en_out=0 and data_mem_write_out=0 for it and for everything after.
  - A halt flagged on a mul instruction does not enter MUL.
- freeze never asserts while halted_out=1.
- Reset mid-MUL: abort, state→IDLE, no writeback, freeze drops asynchronously.
- Back-to-back: a mul following a mul is accepted in the IDLE cycle right after DONE; no lost or duplicated instructions.

Optional Feature:
- Macro: EX_OVF_EN.
- Defined: ovf_out registered with each result.
  - add: carry out of DATA_W bits.
  - sub: borrow (op_a<op_b unsigned).
  - mul: acc[2*DATA_W-1:DATA_W] != 0.
  - and/xor: 0.
- Not defined: ovf_out tied to constant 0; no overflow logic synthesized.

Test Plan:
- Reset, then add: op_a=30, op_b=40, alu=00, adr=5 → next edge result_out=6, wb_en_out=1, write_adr_out=5, ovf_out=1 (if EX_OVF_EN), freeze never high.
- Mul: op_a=7, op_b=9 → freeze high 7 consecutive cycles, result_out=63 on 8th edge, wb_en_out=1, ovf_out=0.
- Mul 12×11 then add 1+2 back-to-back → result_out 4 (ovf_out=1), then 3 one edge after the 4 appears; each wb_en pulse exactly once.
- Store: data_mem_write_in=1, op_b=17 → data_mem_write_out=1, mem_wdata_out=17, wb_en_out=0.
- Halt: accept with halted_in=1, then valid add → halted_out=1 sticky, wb_en_out stays 0, result_out unchanged.
- Reset asserted on 3rd MUL cycle → freeze=0 and all outputs 0 immediately; next instruction after release executes normally.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops plus a DATA_W-cycle shift-add multiply that freezes upstream.
// Optional overflow flag enabled by defining EX_OVF_EN; otherwise ovf_out is constant 0.
module ex_stage #(
    parameter int DATA_W = 6,
    parameter int ADR_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              halted_in,
    input  logic [ADR_W-1:0]  write_adr_in,
    input  logic [1:0]        alu_inst_in,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              data_mem_write_in,
    input  logic              mul_or_add_in,
    output logic              freeze,
    output logic [DATA_W-1:0] result_out,
    output logic [ADR_W-1:0]  write_adr_out,
    output logic              wb_en_out,
    output logic              data_mem_write_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    output logic              halted_out,
    output logic              ovf_out
);

    // state | meaning
    // IDLE  | accepting instructions; ALU ops complete here in one cycle
    // MUL   | shift-add iterations, one multiplier bit per cycle, freeze high
    // DONE  | multiply finished; write back product, upstream advances
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mul_a, mul_b;
    logic [ADR_W-1:0]    mul_adr;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   alu_res;
    logic                accept, start_mul, last_iter;

    assign accept    = (state == IDLE) && in_valid && !halted_out;
    assign start_mul = accept && mul_or_add_in && !halted_in;
    assign last_iter = (cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        alu_res = '0;
        case (alu_inst_in)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b10: alu_res = op_a & op_b;
            2'b11: alu_res = op_a ^ op_b;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_OVF_EN
    logic [DATA_W:0] sum_ext;
    logic            alu_ovf;
    assign sum_ext = {1'b0, op_a} + {1'b0, op_b};
    always_comb begin
        alu_ovf = 1'b0;
        case (alu_inst_in)
            2'b00: alu_ovf = sum_ext[DATA_W];
            2'b01: alu_ovf = (op_a < op_b);
            default: alu_ovf = 1'b0;
        endcase
    end
`else
    assign ovf_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // freeze is gated by rst_n so it drops the moment reset asserts
    always_comb begin
        state_nxt = state;
        freeze    = 1'b0;
        case (state)
            IDLE: begin
                if (start_mul) begin
                    state_nxt = MUL;
                    freeze    = 1'b1;
                end
            end
            MUL: begin
                freeze = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) freeze = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt                <= '0;
            acc                <= '0;
            mul_a              <= '0;
            mul_b              <= '0;
            mul_adr            <= '0;
            result_out         <= '0;
            write_adr_out      <= '0;
            wb_en_out          <= 1'b0;
            data_mem_write_out <= 1'b0;
            mem_wdata_out      <= '0;
            halted_out         <= 1'b0;
`ifdef EX_OVF_EN
            ovf_out            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!accept) begin
                        wb_en_out          <= 1'b0;
                        data_mem_write_out <= 1'b0;
                    end else if (mul_or_add_in) begin
                        wb_en_out          <= 1'b0;
                        data_mem_write_out <= 1'b0;
                        if (halted_in) begin
                            halted_out <= 1'b1;
                        end else begin
                            mul_a   <= op_a;
                            mul_b   <= op_b;
                            mul_adr <= write_adr_in;
                            acc     <= '0;
                            cnt     <= '0;
                        end
                    end else begin
                        result_out         <= alu_res;
                        write_adr_out      <= write_adr_in;
                        mem_wdata_out      <= op_b;
                        data_mem_write_out <= data_mem_write_in && !halted_in;
                        wb_en_out          <= !data_mem_write_in && !halted_in;
                        if (halted_in) halted_out <= 1'b1;
`ifdef EX_OVF_EN
                        ovf_out            <= alu_ovf;
`endif
                    end
                end
                MUL: begin
                    if (mul_b[cnt]) acc <= acc + ({{DATA_W{1'b0}}, mul_a} << cnt);
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    result_out         <= acc[DATA_W-1:0];
                    write_adr_out      <= mul_adr;
                    wb_en_out          <= 1'b1;
                    data_mem_write_out <= 1'b0;
`ifdef EX_OVF_EN
                    ovf_out            <= |acc[2*DATA_W-1:DATA_W];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: arithmetic reference model plus directed vectors.
module tb_ex_stage;
    localparam int DATA_W = 6;
    localparam int ADR_W  = 6;
    localparam int MOD    = 1 << DATA_W;
`ifdef EX_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, halted_in, data_mem_write_in, mul_or_add_in;
    logic [ADR_W-1:0]  write_adr_in;
    logic [1:0]        alu_inst_in;
    logic [DATA_W-1:0] op_a, op_b;
    logic              freeze, wb_en_out, data_mem_write_out, halted_out, ovf_out;
    logic [DATA_W-1:0] result_out, mem_wdata_out;
    logic [ADR_W-1:0]  write_adr_out;

    ex_stage #(.DATA_W(DATA_W), .ADR_W(ADR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .halted_in(halted_in),
        .write_adr_in(write_adr_in), .alu_inst_in(alu_inst_in), .op_a(op_a), .op_b(op_b),
        .data_mem_write_in(data_mem_write_in), .mul_or_add_in(mul_or_add_in),
        .freeze(freeze), .result_out(result_out), .write_adr_out(write_adr_out),
        .wb_en_out(wb_en_out), .data_mem_write_out(data_mem_write_out),
        .mem_wdata_out(mem_wdata_out), .halted_out(halted_out), .ovf_out(ovf_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int fcnt   = 0;
    int wbcnt  = 0;

    // reference model of the architecturally visible outputs
    int m_res, m_adr, m_wdata;
    bit m_wb, m_dmw, m_halt, m_ovf, m_freeze;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (freeze)    fcnt++;
        if (wb_en_out) wbcnt++;
        if (chk_en) begin
            check("freeze",     int'(freeze),             int'(m_freeze));
            check("result",     int'(result_out),         m_res);
            check("write_adr",  int'(write_adr_out),      m_adr);
            check("wb_en",      int'(wb_en_out),          int'(m_wb));
            check("dmem_write", int'(data_mem_write_out), int'(m_dmw));
            check("mem_wdata",  int'(mem_wdata_out),      m_wdata);
            check("halted",     int'(halted_out),         int'(m_halt));
            check("ovf",        int'(ovf_out),            int'(m_ovf));
        end
    end

    task automatic model_clear();
        m_res = 0; m_adr = 0; m_wdata = 0;
        m_wb = 0; m_dmw = 0; m_halt = 0; m_ovf = 0; m_freeze = 0;
    endtask

    // Called just after a rising edge; returns just after the edge that completes the instruction.
    task automatic issue(input bit v, input bit h, input int adr, input int alu,
                         input int a, input int b, input bit st, input bit ml);
        bit acc_ok;
        int r, p;
        in_valid = v; halted_in = h; write_adr_in = ADR_W'(adr); alu_inst_in = 2'(alu);
        op_a = DATA_W'(a); op_b = DATA_W'(b); data_mem_write_in = st; mul_or_add_in = ml;
        acc_ok   = v && !m_halt;
        m_freeze = acc_ok && ml && !h;
        @(posedge clk); #1;
        if (!acc_ok) begin
            m_wb = 0; m_dmw = 0;
        end else if (ml && h) begin
            m_halt = 1; m_wb = 0; m_dmw = 0;
        end else if (ml) begin
            m_wb = 0; m_dmw = 0;
            repeat (DATA_W) @(posedge clk);
            #1;
            m_freeze = 0;
            @(posedge clk); #1;
            p = a * b;
            m_res = p % MOD; m_adr = adr; m_wb = 1; m_dmw = 0;
            m_ovf = OVF_EN && (p >= MOD);
        end else begin
            case (alu)
                0: begin r = a + b;        m_ovf = OVF_EN && (r >= MOD); end
                1: begin r = a - b + MOD;  m_ovf = OVF_EN && (a < b);    end
                2: begin r = a & b;        m_ovf = 0; end
                default: begin r = a ^ b;  m_ovf = 0; end
            endcase
            m_res = r % MOD; m_adr = adr; m_wdata = b;
            m_dmw = st && !h; m_wb = !st && !h;
            if (h) m_halt = 1;
        end
    endtask

    task automatic bubble();
        issue(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        chk_en = 0;
        rst_n = 0; in_valid = 0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1;
        chk_en = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; in_valid = 0; halted_in = 0; write_adr_in = '0; alu_inst_in = '0;
        op_a = '0; op_b = '0; data_mem_write_in = 0; mul_or_add_in = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_freeze", int'(freeze), 0);
        check("reset_result", int'(result_out), 0);
        check("reset_wb",     int'(wb_en_out), 0);
        check("reset_halted", int'(halted_out), 0);
        rst_n = 1;
        chk_en = 1;

        // add 30+40 wraps to 6 with carry
        fcnt = 0;
        issue(1, 0, 5, 0, 30, 40, 0, 0);
        check("add_result", int'(result_out), 6);
        check("add_wb",     int'(wb_en_out), 1);
        check("add_adr",    int'(write_adr_out), 5);
        check("add_ovf",    int'(ovf_out), OVF_EN ? 1 : 0);
        bubble();
        check("add_nofreeze", fcnt, 0);

        // 7*9 = 63
        fcnt = 0;
        issue(1, 0, 9, 0, 7, 9, 0, 1);
        check("mul_result", int'(result_out), 63);
        check("mul_wb",     int'(wb_en_out), 1);
        check("mul_ovf",    int'(ovf_out), 0);
        bubble();
        check("mul_freeze_cycles", fcnt, DATA_W + 1);

        // 12*11 = 132 -> 4, then 1+2 back-to-back
        wbcnt = 0;
        issue(1, 0, 3, 0, 12, 11, 0, 1);
        check("mul2_result", int'(result_out), 4);
        check("mul2_ovf",    int'(ovf_out), OVF_EN ? 1 : 0);
        issue(1, 0, 4, 0, 1, 2, 0, 0);
        check("b2b_add_result", int'(result_out), 3);
        check("b2b_add_adr",    int'(write_adr_out), 4);
        bubble();
        bubble();
        check("b2b_wb_pulses", wbcnt, 2);

        // sub / and / xor
        issue(1, 0, 10, 1, 5, 9, 0, 0);
        check("sub_result", int'(result_out), 60);
        check("sub_ovf",    int'(ovf_out), OVF_EN ? 1 : 0);
        issue(1, 0, 11, 2, 42, 15, 0, 0);
        check("and_result", int'(result_out), 10);
        issue(1, 0, 12, 3, 42, 63, 0, 0);
        check("xor_result", int'(result_out), 21);

        // max operands multiply: 63*63 = 3969 -> 1
        issue(1, 0, 13, 0, 63, 63, 0, 1);
        check("mul_max_result", int'(result_out), 1);

        // store
        issue(1, 0, 7, 0, 3, 17, 1, 0);
        check("store_dmw",   int'(data_mem_write_out), 1);
        check("store_wdata", int'(mem_wdata_out), 17);
        check("store_wb",    int'(wb_en_out), 0);
        bubble();

        // halt, then valid add and a mul must be ignored
        issue(1, 1, 2, 0, 1, 1, 0, 0);
        check("halt_sticky", int'(halted_out), 1);
        check("halt_wb",     int'(wb_en_out), 0);
        issue(1, 0, 6, 0, 10, 10, 0, 0);
        check("post_halt_result", int'(result_out), 2);
        check("post_halt_wb",     int'(wb_en_out), 0);
        fcnt = 0;
        issue(1, 0, 6, 0, 3, 3, 0, 1);
        bubble();
        check("post_halt_nofreeze", fcnt, 0);

        // halt flagged on a mul must not enter MUL
        do_reset();
        fcnt = 0;
        issue(1, 1, 8, 0, 5, 5, 0, 1);
        bubble();
        check("halt_mul_nofreeze", fcnt, 0);
        check("halt_mul_halted",   int'(halted_out), 1);

        // reset in the third MUL cycle
        do_reset();
        issue(1, 0, 5, 0, 30, 40, 0, 0);
        chk_en = 0;
        in_valid = 1; halted_in = 0; mul_or_add_in = 1; op_a = 6'd5; op_b = 6'd5;
        write_adr_in = 6'd9;
        repeat (3) @(posedge clk);
        #1;
        check("mid_mul_freeze_before", int'(freeze), 1);
        rst_n = 0;
        #1;
        check("rst_freeze", int'(freeze), 0);
        check("rst_result", int'(result_out), 0);
        check("rst_wb",     int'(wb_en_out), 0);
        check("rst_adr",    int'(write_adr_out), 0);
        in_valid = 0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1;
        chk_en = 1;
        issue(1, 0, 1, 0, 2, 3, 0, 0);
        check("after_rst_result", int'(result_out), 5);
        check("after_rst_wb",     int'(wb_en_out), 1);
        bubble();
        bubble();

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
